// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   General-purpose register file for the processor datapath. It has one
//   synchronous write port and two independent combinational read ports.
//   Every register, including index 0, can be read and written; none is
//   hardwired to zero.
//
// Parameters
//   WORD_SIZE    width of each register and of every data port
//   INDEX_WIDTH  width of the index ports; the file holds 2**INDEX_WIDTH registers
//
// Ports
//   clk       in   system clock; all state changes on the rising edge
//   reset     in   synchronous, active-low; clears every register to 0
//   wrtEn     in   write enable
//   wrtRegno  in   index of the register to write
//   dataIn    in   write data
//   regno1    in   read port 1 index
//   regno2    in   read port 2 index
//   dataOut1  out  contents of register regno1 (combinational)
//   dataOut2  out  contents of register regno2 (combinational)
//
// Configuration
//   REGFILE_WRITE_BYPASS_EN  when defined, a read port whose index matches an
//   active write (wrtEn high, reset high) shows dataIn in the same cycle,
//   before the edge. When undefined, the read ports show stored contents only.
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int WORD_SIZE   = 32,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wrtEn,
    input  logic [INDEX_WIDTH-1:0] wrtRegno,
    input  logic [WORD_SIZE-1:0]   dataIn,
    input  logic [INDEX_WIDTH-1:0] regno1,
    input  logic [INDEX_WIDTH-1:0] regno2,
    output logic [WORD_SIZE-1:0]   dataOut1,
    output logic [WORD_SIZE-1:0]   dataOut2
);

    localparam int NUM_REGS = 2 ** INDEX_WIDTH;

    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [WORD_SIZE-1:0] regs_d [NUM_REGS];

    // Next-state contents: hold everything, then overlay the enabled write.
    always_comb begin
        // NOTE: the whole array is assigned its held value before the
        // conditional write. Every path then assigns every element, so the
        // block stays purely combinational and no latch is inferred.
        regs_d = regs_q;
        if (wrtEn) begin
            regs_d[wrtRegno] = dataIn;
        end
    end

    // Reset has priority over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: this storage is deliberately reset. Each register is a
            // flop with a synchronous clear, not a RAM macro, so the reset
            // costs no extra ports and it guarantees that the reads are
            // never X after the first reset edge.
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: sequential state always uses non-blocking
                // assignments. Then every flop samples pre-edge values,
                // whatever order the simulator evaluates the blocks in.
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    // Forward the in-flight write data to any read port that addresses the
    // register being written this cycle.
    logic wr_active;
    assign wr_active = wrtEn && reset;

    always_comb begin
        dataOut1 = (wr_active && (regno1 == wrtRegno)) ? dataIn : regs_q[regno1];
        dataOut2 = (wr_active && (regno2 == wrtRegno)) ? dataIn : regs_q[regno2];
    end
`else
    always_comb begin
        dataOut1 = regs_q[regno1];
        dataOut2 = regs_q[regno2];
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
//   Self-checking bench for reg_file. It runs the directed scenarios first and
//   then randomized traffic, comparing both read ports against an array model
//   of the register contents. The bench honours REGFILE_WRITE_BYPASS_EN in the
//   same way as the design, so it can be compiled with either build.
// -----------------------------------------------------------------------------
module tb_reg_file;

    localparam int W  = 32;
    localparam int IW = 4;
    localparam int N  = 2 ** IW;

    logic          clk = 1'b0;
    logic          reset;
    logic          wrtEn;
    logic [IW-1:0] wrtRegno;
    logic [W-1:0]  dataIn;
    logic [IW-1:0] regno1;
    logic [IW-1:0] regno2;
    logic [W-1:0]  dataOut1;
    logic [W-1:0]  dataOut2;

    reg_file #(.WORD_SIZE(W), .INDEX_WIDTH(IW)) dut (
        .clk      (clk),
        .reset    (reset),
        .wrtEn    (wrtEn),
        .wrtRegno (wrtRegno),
        .dataIn   (dataIn),
        .regno1   (regno1),
        .regno2   (regno2),
        .dataOut1 (dataOut1),
        .dataOut2 (dataOut2)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference contents of the register file.
    logic [W-1:0] model [N];

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // The value a read port should show right now, given the current inputs.
    function automatic logic [W-1:0] expected_read(input logic [IW-1:0] idx);
        if (BYPASS && wrtEn && reset && idx == wrtRegno) return dataIn;
        return model[idx];
    endfunction

    // Advance one rising edge, apply the model's view of that edge, then
    // settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < N; i++) model[i] = '0;
        end else if (wrtEn) begin
            model[wrtRegno] = dataIn;
        end
        #1;
    endtask

    task automatic write_reg(input logic [IW-1:0] idx, input logic [W-1:0] val);
        reset = 1'b1; wrtEn = 1'b1; wrtRegno = idx; dataIn = val;
        step();
        wrtEn = 1'b0;
    endtask

    initial begin
        reset = 1'b0; wrtEn = 1'b0; wrtRegno = '0; dataIn = '0;
        regno1 = '0; regno2 = '0;
        for (int i = 0; i < N; i++) model[i] = 'x;
        #2;
        step();
        reset = 1'b1;

        // Reset clear: fill with ones, reset for one edge, sweep both ports.
        for (int i = 0; i < N; i++) write_reg(IW'(i), 32'hFFFF_FFFF);
        regno1 = 4'd9; #1;
        check("fill", dataOut1, 32'hFFFF_FFFF);
        reset = 1'b0; step(); reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            regno1 = IW'(i); regno2 = IW'(N - 1 - i); #1;
            check("reset_clear_p1", dataOut1, 32'h0);
            check("reset_clear_p2", dataOut2, 32'h0);
        end

        // Basic write/read; register 0 is untouched.
        write_reg(4'd1, 32'd8675309);
        regno1 = 4'd1; regno2 = 4'd0; #1;
        check("basic_wr", dataOut1, 32'd8675309);
        check("reg0_zero", dataOut2, 32'h0);

        // Register 0 is an ordinary register.
        write_reg(4'd0, 32'hDEAD_BEEF);
        #1;
        check("reg0_write", dataOut2, 32'hDEAD_BEEF);

        // Dual read, then swap the indices with no clock edge.
        write_reg(4'd3, 32'hA5A5_A5A5);
        write_reg(4'd12, 32'h5A5A_5A5A);
        regno1 = 4'd3; regno2 = 4'd12; #1;
        check("dual_p1", dataOut1, 32'hA5A5_A5A5);
        check("dual_p2", dataOut2, 32'h5A5A_5A5A);
        regno1 = 4'd12; regno2 = 4'd3; #1;
        check("swap_p1", dataOut1, 32'h5A5A_5A5A);
        check("swap_p2", dataOut2, 32'hA5A5_A5A5);

        // Both ports addressing the same register.
        regno1 = 4'd3; regno2 = 4'd3; #1;
        check("same_p1", dataOut1, 32'hA5A5_A5A5);
        check("same_p2", dataOut2, 32'hA5A5_A5A5);

        // Write-enable gating.
        write_reg(4'd5, 32'h11);
        wrtEn = 1'b0; wrtRegno = 4'd5; dataIn = 32'h22;
        step();
        regno1 = 4'd5; #1;
        check("wen_gate", dataOut1, 32'h11);

        // Reset priority over a write.
        write_reg(4'd7, 32'h33);
        reset = 1'b0; wrtEn = 1'b1; wrtRegno = 4'd7; dataIn = 32'h44;
        step();
        reset = 1'b1; wrtEn = 1'b0;
        regno1 = 4'd7; regno2 = 4'd5; #1;
        check("rst_prio", dataOut1, 32'h0);
        check("rst_prio_other", dataOut2, 32'h0);

        // Read/write collision on the same index.
        write_reg(4'd2, 32'h10);
        regno1 = 4'd2; wrtEn = 1'b1; wrtRegno = 4'd2; dataIn = 32'h20; #1;
        check("collide_pre", dataOut1, BYPASS ? 32'h20 : 32'h10);
        step();
        wrtEn = 1'b0; #1;
        check("collide_post", dataOut1, 32'h20);

        // Randomized traffic against the model. Occasional resets, frequent
        // index collisions with the write port.
        for (int it = 0; it < 400; it++) begin
            reset    = ($urandom_range(0, 24) != 0);
            wrtEn    = 1'($urandom_range(0, 1));
            wrtRegno = IW'($urandom);
            dataIn   = $urandom;
            regno1   = ($urandom_range(0, 3) == 0) ? wrtRegno : IW'($urandom);
            regno2   = ($urandom_range(0, 3) == 0) ? wrtRegno : IW'($urandom);
            #1;
            check("rand_pre_p1", dataOut1, expected_read(regno1));
            check("rand_pre_p2", dataOut2, expected_read(regno2));
            step();
            regno1 = IW'($urandom);
            regno2 = IW'($urandom);
            #1;
            check("rand_post_p1", dataOut1, expected_read(regno1));
            check("rand_post_p2", dataOut2, expected_read(regno2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Backstop so a stalled run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
